// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcodes, ALUOp codes, FSM states and mux selects for
//                the multicycle MIPS main control.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int OPC_W = 6;
    localparam int AOP_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    // Encodings shared with the ALU control unit; keep both sides in step.
    localparam logic [AOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [AOP_W-1:0] ALUOP_ORI   = 3'b001;
    localparam logic [AOP_W-1:0] ALUOP_LUI   = 3'b010;
    localparam logic [AOP_W-1:0] ALUOP_ANDI  = 3'b011;
    localparam logic [AOP_W-1:0] ALUOP_SUB   = 3'b100;
    localparam logic [AOP_W-1:0] ALUOP_LW    = 3'b101;
    localparam logic [AOP_W-1:0] ALUOP_SW    = 3'b110;
    localparam logic [AOP_W-1:0] ALUOP_RTYPE = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_R_EXEC    = 4'd3,
        S_R_WB      = 4'd4,
        S_I_EXEC    = 4'd5,
        S_I_WB      = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_LW_WB     = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12
    } state_e;

    typedef struct packed {
        logic             pc_en;
        logic             pc_write;
        logic             branch;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       pc_source;
        logic [AOP_W-1:0] alu_op;
        logic             instr_done;
        logic             illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI, OP_ANDI,
            OP_BEQ, OP_LW, OP_SW, OP_J: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic [AOP_W-1:0] i_type_alu_op(input logic [OPC_W-1:0] op);
        case (op)
            OP_ORI:  return ALUOP_ORI;
            OP_LUI:  return ALUOP_LUI;
            OP_ANDI: return ALUOP_ANDI;
            default: return ALUOP_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_decode.sv
// ============================================================================
//  Module      : mc_control_decode
//  Description : Combinational map from FSM state and status inputs to the
//                multicycle datapath control word.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_control_decode
    import mips_pkg::*;
(
    input  state_e           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output ctrl_t            ctrl
);

    ctrl_t c;

    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
                c.ir_write  = mem_ready;
                c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                c.alu_src_b  = SRCB_IMM_SH2;
                c.alu_op     = ALUOP_ADD;
                c.illegal_op = ~is_legal_op(opcode);
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_RT;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                c.reg_dst    = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = i_type_alu_op(opcode);
            end
            S_I_WB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = (opcode == OP_SW) ? ALUOP_SW : ALUOP_LW;
            end
            S_MEM_READ: begin
                c.i_or_d   = 1'b1;
                c.mem_read = 1'b1;
            end
            S_LW_WB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                c.i_or_d     = 1'b1;
                c.mem_write  = 1'b1;
                c.instr_done = mem_ready;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_RT;
                c.alu_op     = ALUOP_SUB;
                c.pc_source  = PCSRC_ALUOUT;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pc_source  = PCSRC_JUMP;
                c.pc_write   = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        c.pc_en = c.pc_write | (c.branch & zero);
    end

    assign ctrl = c;

endmodule

`default_nettype wire

// File: rtl/multicycle_main_control.sv
// ============================================================================
//  Module      : multicycle_main_control
//  Description : Main control FSM for the multicycle MIPS datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_main_control
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_en,
    output logic                pc_write,
    output logic                branch,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_source,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                instr_done,
    output logic                illegal_op
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                        state_d = S_R_EXEC;
                    OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: state_d = S_I_EXEC;
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_BEQ:                          state_d = S_BRANCH;
                    OP_J:                            state_d = S_JUMP;
                    default:                         state_d = S_FETCH;
                endcase
            end
            S_R_EXEC:    state_d = S_R_WB;
            S_I_EXEC:    state_d = S_I_WB;
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_LW_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            // Writeback, branch, jump and unreachable encodings all restart fetch.
            default:     state_d = S_FETCH;
        endcase
    end

    mc_control_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    always_comb begin
        pc_en      = ctrl.pc_en;
        pc_write   = ctrl.pc_write;
        branch     = ctrl.branch;
        i_or_d     = ctrl.i_or_d;
        mem_read   = ctrl.mem_read;
        mem_write  = ctrl.mem_write;
        ir_write   = ctrl.ir_write;
        reg_dst    = ctrl.reg_dst;
        mem_to_reg = ctrl.mem_to_reg;
        reg_write  = ctrl.reg_write;
        alu_src_a  = ctrl.alu_src_a;
        alu_src_b  = ctrl.alu_src_b;
        pc_source  = ctrl.pc_source;
        alu_op     = ctrl.alu_op;
        instr_done = ctrl.instr_done;
        illegal_op = ctrl.illegal_op;
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_control.sv
// ============================================================================
//  Module      : tb_multicycle_main_control
//  Description : Directed, table-driven bench for multicycle_main_control.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_main_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       zero;
    logic       pc_en, pc_write, branch, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       instr_done, illegal_op;

    multicycle_main_control #(.OPCODE_W(6), .ALUOP_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .pc_en      (pc_en),
        .pc_write   (pc_write),
        .branch     (branch),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_source  (pc_source),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output word: {pc_en,pc_write,branch,i_or_d,mem_read,mem_write,ir_write,
    //               reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,pc_source,alu_op,
    //               instr_done,illegal_op}
    logic [19:0] act;
    assign act = {pc_en, pc_write, branch, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
                  alu_op, instr_done, illegal_op};

    localparam logic [19:0] M_PCEN = 20'd1 << 19;
    localparam logic [19:0] M_PCW  = 20'd1 << 18;
    localparam logic [19:0] M_BR   = 20'd1 << 17;
    localparam logic [19:0] M_IORD = 20'd1 << 16;
    localparam logic [19:0] M_MRD  = 20'd1 << 15;
    localparam logic [19:0] M_MWR  = 20'd1 << 14;
    localparam logic [19:0] M_IRW  = 20'd1 << 13;
    localparam logic [19:0] M_RDST = 20'd1 << 12;
    localparam logic [19:0] M_M2R  = 20'd1 << 11;
    localparam logic [19:0] M_RW   = 20'd1 << 10;
    localparam logic [19:0] M_SRCA = 20'd1 << 9;
    localparam logic [19:0] M_DONE = 20'd1 << 1;
    localparam logic [19:0] M_ILL  = 20'd1;

    function automatic logic [19:0] srcb(input logic [1:0] v);
        return {11'b0, v, 7'b0};
    endfunction
    function automatic logic [19:0] pcs(input logic [1:0] v);
        return {13'b0, v, 5'b0};
    endfunction
    function automatic logic [19:0] aop(input logic [2:0] v);
        return {15'b0, v, 2'b0};
    endfunction

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        rdy;
        logic        z;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [19:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic rdy,
                       input logic z, input logic [19:0] exp);
        vec_t v;
        v.name = name; v.op = op; v.rdy = rdy; v.z = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One cycle: drive just after the rising edge, sample at the falling edge.
    task automatic step(input string name, input logic [5:0] op, input logic rdy,
                        input logic z, input logic [19:0] exp);
        opcode = op; mem_ready = rdy; zero = z;
        @(negedge clk);
        check(name, exp);
        @(posedge clk);
        #1;
    endtask

    logic [19:0] f_wait, f_rdy, dec;

    initial begin
        f_wait = M_MRD | srcb(2'b01);
        f_rdy  = M_MRD | M_IRW | M_PCW | M_PCEN | srcb(2'b01);
        dec    = srcb(2'b11);

        // ADD
        add("add_fetch",  6'b000000, 1, 0, f_rdy);
        add("add_dec",    6'b000000, 1, 0, dec);
        add("add_rexec",  6'b000000, 1, 0, M_SRCA | aop(3'b111));
        add("add_rwb",    6'b000000, 1, 0, M_RDST | M_RW | M_DONE);
        // LW with 2 fetch and 3 read wait cycles: 10 cycles
        add("lw_fwait0",  6'b100011, 0, 0, f_wait);
        add("lw_fwait1",  6'b100011, 0, 0, f_wait);
        add("lw_fetch",   6'b100011, 1, 0, f_rdy);
        add("lw_dec",     6'b100011, 1, 0, dec);
        add("lw_addr",    6'b100011, 1, 0, M_SRCA | srcb(2'b10) | aop(3'b101));
        add("lw_rwait0",  6'b100011, 0, 0, M_IORD | M_MRD);
        add("lw_rwait1",  6'b100011, 0, 0, M_IORD | M_MRD);
        add("lw_rwait2",  6'b100011, 0, 0, M_IORD | M_MRD);
        add("lw_read",    6'b100011, 1, 0, M_IORD | M_MRD);
        add("lw_wb",      6'b100011, 1, 0, M_M2R | M_RW | M_DONE);
        // BEQ taken / not taken
        add("beq1_fetch", 6'b000100, 1, 1, f_rdy);
        add("beq1_dec",   6'b000100, 1, 1, dec);
        add("beq1_br",    6'b000100, 1, 1, M_SRCA | aop(3'b100) | pcs(2'b01) | M_BR | M_DONE | M_PCEN);
        add("beq0_fetch", 6'b000100, 1, 0, f_rdy);
        add("beq0_dec",   6'b000100, 1, 0, dec);
        add("beq0_br",    6'b000100, 1, 0, M_SRCA | aop(3'b100) | pcs(2'b01) | M_BR | M_DONE);
        // SW with one write wait cycle
        add("sw_fetch",   6'b101011, 1, 0, f_rdy);
        add("sw_dec",     6'b101011, 1, 0, dec);
        add("sw_addr",    6'b101011, 1, 0, M_SRCA | srcb(2'b10) | aop(3'b110));
        add("sw_wwait",   6'b101011, 0, 0, M_IORD | M_MWR);
        add("sw_write",   6'b101011, 1, 0, M_IORD | M_MWR | M_DONE);
        // I-type group
        add("ori_fetch",  6'b001101, 1, 0, f_rdy);
        add("ori_dec",    6'b001101, 1, 0, dec);
        add("ori_exec",   6'b001101, 1, 0, M_SRCA | srcb(2'b10) | aop(3'b001));
        add("ori_wb",     6'b001101, 1, 0, M_RW | M_DONE);
        add("lui_fetch",  6'b001111, 1, 0, f_rdy);
        add("lui_dec",    6'b001111, 1, 0, dec);
        add("lui_exec",   6'b001111, 1, 0, M_SRCA | srcb(2'b10) | aop(3'b010));
        add("lui_wb",     6'b001111, 1, 0, M_RW | M_DONE);
        add("andi_fetch", 6'b001100, 1, 0, f_rdy);
        add("andi_dec",   6'b001100, 1, 0, dec);
        add("andi_exec",  6'b001100, 1, 0, M_SRCA | srcb(2'b10) | aop(3'b011));
        add("andi_wb",    6'b001100, 1, 0, M_RW | M_DONE);
        add("addi_fetch", 6'b001000, 1, 0, f_rdy);
        add("addi_dec",   6'b001000, 1, 0, dec);
        add("addi_exec",  6'b001000, 1, 1, M_SRCA | srcb(2'b10) | aop(3'b000));
        add("addi_wb",    6'b001000, 1, 1, M_RW | M_DONE);
        // Jump
        add("j_fetch",    6'b000010, 1, 0, f_rdy);
        add("j_dec",      6'b000010, 1, 0, dec);
        add("j_jump",     6'b000010, 1, 0, pcs(2'b10) | M_PCW | M_PCEN | M_DONE);
        // Illegal opcode returns to FETCH
        add("ill_fetch",  6'b111111, 1, 0, f_rdy);
        add("ill_dec",    6'b111111, 1, 0, dec | M_ILL);
        add("ill_refetch",6'b111111, 0, 0, f_wait);

        opcode = 6'b000000; mem_ready = 1'b1; zero = 1'b1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset held with mem_ready/zero high: nothing may be enabled.
        @(negedge clk);
        check("reset_hold", 20'd0);
        #1 reset = 1'b0;
        check("idle", 20'd0);
        @(posedge clk);
        #1;
        step("fetch_after_idle", 6'b000000, 0, 0, f_wait);

        // Reset asserted mid-FETCH aborts the fetch.
        mem_ready = 1'b1;
        #1 check("fetch_ready_pre_reset", f_rdy);
        reset = 1'b1;
        #1 check("reset_mid_fetch", 20'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 20'd0);
        @(posedge clk);
        #1;

        foreach (vecs[i]) step(vecs[i].name, vecs[i].op, vecs[i].rdy, vecs[i].z, vecs[i].exp);

        // The illegal sequence left the FSM in FETCH; run SW into MEM_WRITE, then reset.
        step("sw2_fetch", 6'b101011, 1, 0, f_rdy);
        step("sw2_dec",   6'b101011, 1, 0, dec);
        step("sw2_addr",  6'b101011, 1, 0, M_SRCA | srcb(2'b10) | aop(3'b110));
        opcode = 6'b101011; mem_ready = 1'b1;
        @(negedge clk);
        check("sw2_write", M_IORD | M_MWR | M_DONE);
        reset = 1'b1;
        #1 check("reset_mid_write", 20'd0);
        @(posedge clk);
        #1 check("reset_edge_hold", 20'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        step("fetch_after_write_reset", 6'b000000, 0, 0, f_wait);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
